// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings and constants for the RV32I fetch path.
package riscv_pkg;
    localparam logic [1:0]  PCSRC_SEQ  = 2'b00;
    localparam logic [1:0]  PCSRC_BR   = 2'b01;
    localparam logic [1:0]  PCSRC_JALR = 2'b10;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    typedef enum logic [1:0] {REQ, WAIT, KILL} fetch_state_e;
endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: picks the next fetch PC from the EX-stage PC-source selection.
module pc_next_mux
    import riscv_pkg::*;
(
    input  logic [1:0]  pc_src_i,
    input  logic [31:0] pcf_i,
    input  logic [31:0] pc_target_i,
    input  logic [31:0] alu_result_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] pc_next_o,
    output logic        redirect_o
);
    assign pc_plus4_o = pcf_i + 32'd4;
    assign redirect_o = pc_src_i == PCSRC_BR || pc_src_i == PCSRC_JALR;
    // Reserved encoding 11 falls through to sequential.
    assign pc_next_o  = pc_src_i == PCSRC_BR   ? pc_target_i :
                        pc_src_i == PCSRC_JALR ? alu_result_i & ~32'd1 : pc_plus4_o;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with single-outstanding imem handshake, one-entry
// holding buffer and the IF/ID pipeline register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] ALUResultE,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);
    import riscv_pkg::*;
    fetch_state_e state_q, state_d;
    logic [31:0] pcf_q, pcf_d, instr_q, instr_d, pcd_q, pcd_d, pcp4_q, pcp4_d;
    logic [31:0] buf_instr_q, buf_instr_d, buf_pc_q, buf_pc_d, pc_next, pc_plus4;
    logic        valid_q, valid_d, buf_valid_q, buf_valid_d;
    logic        redirect, hs, rsp_ok, busy;

    pc_next_mux u_pc_next_mux (
        .pc_src_i    (PCSrcE),
        .pcf_i       (pcf_q),
        .pc_target_i (PCTargetE),
        .alu_result_i(ALUResultE),
        .pc_plus4_o  (pc_plus4),
        .pc_next_o   (pc_next),
        .redirect_o  (redirect)
    );

    assign imem_req_valid = !rst && state_q == REQ && !StallF && !buf_valid_q;
    assign imem_req_addr  = pcf_q;
    assign hs             = imem_req_valid && imem_req_ready;
    assign rsp_ok         = state_q == WAIT && imem_rsp_valid;
    // A response is still owed after this cycle: a fresh accept, or WAIT/KILL not yet answered.
    assign busy           = hs || (state_q != REQ && !imem_rsp_valid);

    always_comb begin
        state_d     = state_q;
        pcf_d       = pcf_q;
        buf_valid_d = buf_valid_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        instr_d     = instr_q;
        pcd_d       = pcd_q;
        pcp4_d      = pcp4_q;
        valid_d     = valid_q;
        if (redirect) begin
            state_d     = busy ? KILL : REQ;
            pcf_d       = pc_next;
            buf_valid_d = 1'b0;
        end else begin
            if (hs) state_d = WAIT;
            if (state_q == KILL && imem_rsp_valid) state_d = REQ;
            if (rsp_ok) begin
                state_d = REQ;
                pcf_d   = pc_plus4;
                if (StallD) {buf_valid_d, buf_instr_d, buf_pc_d} = {1'b1, imem_rsp_data, pcf_q};
            end else if (buf_valid_q && !StallD && !FlushD) begin
                buf_valid_d = 1'b0;
            end
        end
        if (redirect || FlushD) begin
            {instr_d, pcd_d, pcp4_d, valid_d} = {NOP_INSTR, 64'd0, 1'b0};
        end else if (!StallD) begin
            if (rsp_ok) {instr_d, pcd_d, pcp4_d, valid_d} = {imem_rsp_data, pcf_q, pc_plus4, 1'b1};
            else if (buf_valid_q) {instr_d, pcd_d, pcp4_d, valid_d} = {buf_instr_q, buf_pc_q, buf_pc_q + 32'd4, 1'b1};
            else valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= REQ;
            pcf_q       <= RESET_PC;
            buf_valid_q <= 1'b0;
            buf_instr_q <= NOP_INSTR;
            buf_pc_q    <= 32'd0;
            instr_q     <= NOP_INSTR;
            pcd_q       <= 32'd0;
            pcp4_q      <= 32'd0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pcf_q       <= pcf_d;
            buf_valid_q <= buf_valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            instr_q     <= instr_d;
            pcd_q       <= pcd_d;
            pcp4_q      <= pcp4_d;
            valid_q     <= valid_d;
        end
    end

    assign PCF      = pcf_q;
    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcp4_q;
    assign ValidD   = valid_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus against a transaction-level fetch model
// plus hand-computed literal expectations.
module tb_fetch_unit;
    logic        clk = 1'b0, rst = 1'b1;
    logic [1:0]  PCSrcE = 2'b00;
    logic [31:0] PCTargetE = 32'd0, ALUResultE = 32'd0;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b1, imem_rsp_valid = 1'b0;
    logic [31:0] imem_req_addr, imem_rsp_data = 32'd0;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D;
    logic        ValidD;

    int n_chk = 0, n_fail = 0;
    logic        mem_en = 1'b1, pend = 1'b0, use_ovr = 1'b0;
    logic [31:0] pend_addr = 32'd0, ovr_data = 32'd0;
    logic [31:0] m_pc, m_instr, m_pcd, m_pcp4, m_binstr, m_bpc;
    logic        m_valid, m_bufv, m_out, m_drop;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ALUResultE(ALUResultE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        {m_pc, m_instr, m_pcd, m_pcp4, m_valid} = {32'd0, 32'h13, 64'd0, 1'b0};
        {m_bufv, m_out, m_drop} = 3'b000;
    endtask

    // One clock cycle: memory drives its response, model advances, outputs are compared.
    task automatic cycle();
        logic hs_m, got, deliver, bufv_old, redir;
        logic [31:0] pc_old;
        imem_rsp_valid = mem_en && pend;
        imem_rsp_data  = use_ovr ? ovr_data : {16'hC0DE, pend_addr[15:0]};
        #1;
        hs_m = !m_out && !StallF && !m_bufv;
        chk("req_valid", {31'd0, imem_req_valid}, {31'd0, hs_m});
        if (hs_m) chk("req_addr", imem_req_addr, m_pc);
        hs_m = hs_m && imem_req_ready;
        if (imem_rsp_valid) pend = 1'b0;
        if (imem_req_valid && imem_req_ready) {pend, pend_addr} = {1'b1, imem_req_addr};
        got   = m_out && imem_rsp_valid;
        redir = PCSrcE == 2'b01 || PCSrcE == 2'b10;
        if (redir) begin
            m_out  = (m_out && !imem_rsp_valid) || hs_m;
            m_drop = m_out;
            m_pc   = PCSrcE == 2'b01 ? PCTargetE : {ALUResultE[31:1], 1'b0};
            m_bufv = 1'b0;
            {m_instr, m_pcd, m_pcp4, m_valid} = {32'h13, 64'd0, 1'b0};
        end else begin
            deliver  = got && !m_drop;
            bufv_old = m_bufv;
            pc_old   = m_pc;
            if (got) m_out = 1'b0;
            if (hs_m) {m_out, m_drop} = 2'b10;
            if (deliver) begin
                m_pc = pc_old + 32'd4;
                if (StallD) {m_bufv, m_binstr, m_bpc} = {1'b1, imem_rsp_data, pc_old};
            end
            if (FlushD) {m_instr, m_pcd, m_pcp4, m_valid} = {32'h13, 64'd0, 1'b0};
            else if (!StallD) begin
                if (deliver) {m_instr, m_pcd, m_pcp4, m_valid} = {imem_rsp_data, pc_old, pc_old + 32'd4, 1'b1};
                else if (bufv_old) begin
                    {m_instr, m_pcd, m_pcp4, m_valid} = {m_binstr, m_bpc, m_bpc + 32'd4, 1'b1};
                    m_bufv = 1'b0;
                end else m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("PCF", PCF, m_pc);
        chk("InstrD", InstrD, m_instr);
        chk("PCD", PCD, m_pcd);
        chk("PCPlus4D", PCPlus4D, m_pcp4);
        chk("ValidD", {31'd0, ValidD}, {31'd0, m_valid});
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        chk("rst PCF", PCF, 32'h0);
        chk("rst InstrD", InstrD, 32'h0000_0013);
        chk("rst ValidD", {31'd0, ValidD}, 32'd0);
        chk("rst req_valid", {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run(1);
        chk("seq ValidD c1", {31'd0, ValidD}, 32'd0);
        run(1);
        chk("seq ValidD c2", {31'd0, ValidD}, 32'd1);
        chk("seq InstrD c2", InstrD, 32'hC0DE_0000);
        chk("seq PCF c2", PCF, 32'h4);
        run(2);
        chk("seq InstrD c4", InstrD, 32'hC0DE_0004);
        chk("seq PCD c4", PCD, 32'h4);
        chk("seq PCF c4", PCF, 32'h8);
        run(1);
        // Branch redirect while the response for 0x8 lands in the same cycle.
        {PCSrcE, PCTargetE, use_ovr, ovr_data} = {2'b01, 32'h100, 1'b1, 32'hDEAD_BEEF};
        run(1);
        {PCSrcE, use_ovr} = {2'b00, 1'b0};
        chk("br PCF", PCF, 32'h100);
        chk("br ValidD", {31'd0, ValidD}, 32'd0);
        chk("br InstrD", InstrD, 32'h0000_0013);
        // jalr redirect while the request at 0x100 is being accepted.
        {PCSrcE, ALUResultE} = {2'b10, 32'h203};
        run(1);
        PCSrcE = 2'b00;
        chk("jalr PCF", PCF, 32'h202);
        run(1);
        chk("kill PCF", PCF, 32'h202);
        chk("kill ValidD", {31'd0, ValidD}, 32'd0);
        run(1);
        {StallD, use_ovr, ovr_data} = {1'b1, 1'b1, 32'h00A0_0093};
        run(1);
        use_ovr = 1'b0;
        run(2);
        chk("stall req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("stall ValidD", {31'd0, ValidD}, 32'd0);
        StallD = 1'b0;
        run(1);
        chk("drain InstrD", InstrD, 32'h00A0_0093);
        chk("drain PCD", PCD, 32'h202);
        chk("drain PCPlus4D", PCPlus4D, 32'h206);
        chk("drain ValidD", {31'd0, ValidD}, 32'd1);
        {StallD, FlushD} = 2'b11;
        run(1);
        {StallD, FlushD} = 2'b00;
        chk("flush InstrD", InstrD, 32'h0000_0013);
        chk("flush ValidD", {31'd0, ValidD}, 32'd0);
        chk("flush PCF", PCF, 32'h206);
        mem_en = 1'b0;
        run(1);
        // Asynchronous reset while a response is pending.
        #2 rst = 1'b1;
        #1;
        chk("arst PCF", PCF, 32'h0);
        chk("arst InstrD", InstrD, 32'h0000_0013);
        chk("arst ValidD", {31'd0, ValidD}, 32'd0);
        chk("arst req_valid", {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        mem_en = 1'b1;
        model_reset();
        run(1);
        chk("stale ValidD", {31'd0, ValidD}, 32'd0);
        chk("stale InstrD", InstrD, 32'h0000_0013);
        run(1);
        chk("post-rst InstrD", InstrD, 32'hC0DE_0000);
        {PCSrcE, PCTargetE} = {2'b01, 32'hFFFF_FFFC};
        run(1);
        PCSrcE = 2'b00;
        run(3);
        chk("wrap PCD", PCD, 32'hFFFF_FFFC);
        chk("wrap PCPlus4D", PCPlus4D, 32'h0);
        chk("wrap PCF", PCF, 32'h0);
        StallF = 1'b1;
        run(2);
        chk("stallF PCF", PCF, 32'h0);
        StallF = 1'b0;
        run(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no end of test, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF stage of the pipelined RV32I core.
- Directly downstream of the EX-stage PC-source selector: consumes its 2-bit PCSrcE and redirects fetch.
- Owns PCF and a single-outstanding instruction-memory request/response handshake.
- Owns the IF/ID pipeline register, which honours the hazard unit's stall and flush controls.

Parameters:
- RESET_PC, 32'h0000_0000, PCF value after reset.
- NOP_INSTR, 32'h0000_0013, value loaded into InstrD on flush or reset (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- PCSrcE  in  2  00 sequential, 01 branch/jal target, 10 jalr target, 11 reserved (treated as 00).
- PCTargetE  in  32  branch/jal target (PCE+ImmExtE).
- ALUResultE  in  32  jalr target before bit-0 clear.
- StallF  in  1  hazard unit: hold PCF and issue no new request.
- StallD  in  1  hazard unit: hold IF/ID.
- FlushD  in  1  hazard unit: clear IF/ID.
- imem_req_valid  out  1  request valid.
- imem_req_addr  out  32  request address (= PCF).
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  response data valid.
- imem_rsp_data  in  32  fetched instruction.
- PCF  out  32  current fetch PC.
- InstrD  out  32  IF/ID instruction.
- PCD  out  32  IF/ID PC.
- PCPlus4D  out  32  IF/ID PC+4.
- ValidD  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, rst=1):
  - PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
  - Holding buffer empty; state=REQ; imem_req_valid=0 while rst is high.
- States:
  - REQ: request presented.
  - WAIT: one request accepted, response pending.
  - KILL: in-flight response must be discarded.
- REQ:
  - imem_req_valid=1 when !StallF && !buf_valid.
  - On valid&&ready -> WAIT.
- WAIT:
  - On rsp_valid with !StallD: load IF/ID {rsp_data, PCF, PCF+4}, ValidD=1, PCF<=PCF+4, -> REQ.
  - On rsp_valid with StallD: capture into 1-entry holding buffer (buf_valid=1), PCF<=PCF+4, -> REQ.
  - The next request is not issued until the buffer drains into IF/ID on the first cycle with !StallD.
- KILL:
  - Next rsp_valid is dropped and IF/ID is untouched -> REQ.
  - Redirect rules below still apply in KILL.
- Redirect (PCSrcE=01/10): highest priority in any state, same cycle as the PCSrcE assertion.
  - PCF<=PCTargetE (01) or {ALUResultE[31:1],1'b0} (10).
  - IF/ID flushed (InstrD=NOP_INSTR, ValidD=0), holding buffer cleared.
  - Next state: KILL if a request is outstanding (state WAIT without rsp_valid this cycle, or REQ handshake completing this cycle); otherwise REQ.
  - A response arriving in the redirect cycle is discarded.
- FlushD without redirect: IF/ID cleared; PCF and state unaffected. FlushD beats StallD.
- StallF: PCF held; an outstanding request still completes into IF/ID or the buffer.
- Arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- No misalignment trap: targets pass through unchanged except the jalr bit-0 clear.
- Latency: minimum 2 cycles from request to ValidD with zero-wait memory; throughput 1 instruction per 2 cycles (single outstanding).

Decomposition:
- Shared package (riscv_pkg):
  - PCSrc encodings PCSRC_SEQ=2'b00, PCSRC_BR=2'b01, PCSRC_JALR=2'b10.
  - fetch state enum {REQ, WAIT, KILL}.
  - NOP_INSTR constant.
- Sub-module pc_next_mux: combinational selection of PCF+4 / PCTargetE / jalr-cleared target from PCSrcE. FSM, holding buffer and IF/ID register stay in fetch_unit.

Test Plan:
- Reset release, memory always ready, rsp returns 1 cycle after accept -> requests at 0x0,0x4,0x8; InstrD/PCD follow; ValidD first high 2 cycles after reset release.
- In WAIT, PCSrcE=01, PCTargetE=0x100, rsp arrives same cycle with 0xDEADBEEF -> response dropped, ValidD=0, next request at 0x100.
- PCSrcE=10, ALUResultE=0x203 while in REQ with ready=1 -> PCF=0x202, state KILL, next rsp discarded, next request 0x202.
- Response 0x00A00093 arrives with StallD=1 for 3 cycles -> IF/ID unchanged, no new request; StallD drop -> InstrD=0x00A00093, then request PCF+4.
- FlushD=1 with StallD=1 while ValidD=1 -> InstrD=0x00000013, ValidD=0, PCF unchanged.
- rst asserted mid-WAIT -> outputs immediately at reset values; after release, first request at RESET_PC and the stale response is not written to IF/ID.
